// File: rtl/iomem_pixresp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iomem_pixresp_pkg
//  Description : Shared definitions for the iomem pixel responder: register
//                offsets, CTRL/STATUS bit positions, bus FSM state encoding
//                and a small pop-count helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package iomem_pixresp_pkg;

  // Word offsets decoded from iomem_addr[3:2]
  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_THRESH = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_FLUSH_BIT  = 2;

  // STATUS bit positions
  localparam int STATUS_OVF_BIT  = 8;
  localparam int STATUS_POPN_LSB = 12;

  // Single-byte DATA read of an empty FIFO: only the EMPTY flag is set
  localparam logic [31:0] DATA_EMPTY_WORD = 32'h0000_0100;

  // Bus handshake states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } bus_state_e;

  // Number of bytes a packed DATA read takes: min(count, 4)
  function automatic logic [2:0] min4(input logic [8:0] cnt);
    return (cnt >= 9'd4) ? 3'd4 : cnt[2:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_fifo
//  Description : Synchronous byte FIFO, DEPTH x 8. One push per cycle, a pop
//                of up to four bytes per cycle, synchronous flush, and a
//                four-byte lookahead port presenting the oldest bytes
//                (oldest in [7:0]).
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [7:0]       din_i,
  input  logic             pop_i,
  input  logic [2:0]       pop_n_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic [31:0]      look_o
);

  localparam int AW = $clog2(DEPTH);

  // Storage is not reset: slots beyond the count are never observed
  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] pop_amt;
  logic             push_ok;

  // Next pointers and count; flush wins over any push or pop on the same edge
  always_comb begin
    full_o  = (count_q == CNT_W'(DEPTH));
    push_ok = push_i && !full_o && !flush_i;
    pop_amt = '0;
    if (pop_i && !flush_i) begin
      pop_amt = (CNT_W'(pop_n_i) > count_q) ? count_q : CNT_W'(pop_n_i);
    end
    rp_d    = rp_q + pop_amt[AW-1:0];
    wp_d    = wp_q + AW'(push_ok);
    count_d = count_q + CNT_W'(push_ok) - pop_amt;
    if (flush_i) begin
      rp_d    = wp_q;
      wp_d    = wp_q;
      count_d = '0;
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Byte storage write
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wp_q] <= din_i;
    end
  end

  // Lookahead of the four oldest bytes, pointers wrap modulo DEPTH
  always_comb begin
    look_o = '0;
    for (int i = 0; i < 4; i++) begin
      look_o[8*i +: 8] = mem_q[rp_q + AW'(i)];
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/iomem_pixel_responder.sv
`default_nettype none
// ============================================================================
//  Module      : iomem_pixel_responder
//  Description : iomem bus responder that buffers an 8-bit pixel stream in a
//                FIFO for the CPU to drain through register reads, with a
//                level IRQ on a programmable fill threshold.
//                Optional feature macro IOMEM_PIXRESP_PACK4_EN: DATA reads
//                pop up to four bytes packed little-endian and STATUS[14:12]
//                reports how many the last DATA read popped.
//  Revision    : 1.0 - initial release
// ============================================================================
module iomem_pixel_responder
  import iomem_pixresp_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR_HI = 8'h03,
  parameter int         DEPTH        = 16,
  parameter int         CNT_W        = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  input  logic [7:0]  pixel_in,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic        irq
);

  // Bus FSM and latched request
  bus_state_e       state_q;
  logic             ready_q;
  logic [31:0]      rdata_q;
  logic             req_wr_q;
  logic [1:0]       req_off_q;
  logic [15:0]      req_wdata_q;
  logic [1:0]       req_wstrb_q;
  logic [2:0]       req_popn_q;

  // Register file
  logic             en_q;
  logic             irq_en_q;
  logic             ovf_q;
  logic [CNT_W-1:0] thresh_q;
`ifdef IOMEM_PIXRESP_PACK4_EN
  logic [2:0]       last_popn_q;
`endif

  // FIFO interface
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic [31:0]      fifo_look;

  logic             sel_d;
  logic             is_rd_d;
  logic [31:0]      rd_word_d;
  logic [2:0]       rd_popn_d;
  logic [31:0]      status_word_d;
  logic             commit_d;
  logic             data_rd_d;
  logic             pop_d;
  logic             wr_ctrl_d;
  logic             wr_thresh_d;
  logic             flush_d;
  logic             clr_ovf_d;
  logic             push_d;
  logic             ovf_set_d;
  logic [CNT_W-1:0] thresh_wr_d;

  assign sel_d   = iomem_valid && (iomem_addr[31:24] == BASE_ADDR_HI);
  assign is_rd_d = (iomem_wstrb == 4'b0000);

  // Read data and pop count, evaluated from the state seen when the request is sampled
  always_comb begin
    rd_word_d     = '0;
    rd_popn_d     = '0;
    status_word_d = '0;
    status_word_d[7:0]            = 8'(fifo_count);
    status_word_d[STATUS_OVF_BIT] = ovf_q;
`ifdef IOMEM_PIXRESP_PACK4_EN
    status_word_d[STATUS_POPN_LSB +: 3] = last_popn_q;
`endif
    case (iomem_addr[3:2])
      OFF_DATA: begin
`ifdef IOMEM_PIXRESP_PACK4_EN
        rd_popn_d = min4(9'(fifo_count));
        for (int i = 0; i < 4; i++) begin
          if (3'(i) < rd_popn_d) begin
            rd_word_d[8*i +: 8] = fifo_look[8*i +: 8];
          end
        end
`else
        if (fifo_count == '0) begin
          rd_word_d = DATA_EMPTY_WORD;
        end else begin
          rd_word_d = {24'b0, fifo_look[7:0]};
          rd_popn_d = 3'd1;
        end
`endif
      end
      OFF_STATUS: rd_word_d = status_word_d;
      OFF_CTRL: begin
        rd_word_d[CTRL_EN_BIT]     = en_q;
        rd_word_d[CTRL_IRQ_EN_BIT] = irq_en_q;
      end
      default: rd_word_d = 32'(thresh_q);
    endcase
  end

  // Bus handshake: one-cycle ack, then hold until the initiator drops valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      req_wr_q    <= 1'b0;
      req_off_q   <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      req_popn_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_d) begin
            state_q     <= ST_ACK;
            ready_q     <= 1'b1;
            rdata_q     <= is_rd_d ? rd_word_d : '0;
            req_wr_q    <= !is_rd_d;
            req_off_q   <= iomem_addr[3:2];
            req_wdata_q <= iomem_wdata[15:0];
            req_wstrb_q <= iomem_wstrb[1:0];
            req_popn_q  <= is_rd_d ? rd_popn_d : '0;
          end
        end
        ST_ACK: begin
          state_q <= ST_HOLD;
          ready_q <= 1'b0;
          rdata_q <= '0;
        end
        ST_HOLD: begin
          if (!iomem_valid) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Side effects of the acknowledged request, applied at the edge closing the ack cycle
  assign commit_d    = (state_q == ST_ACK);
  assign data_rd_d   = commit_d && !req_wr_q && (req_off_q == OFF_DATA);
  assign pop_d       = data_rd_d && (req_popn_q != 3'd0);
  assign wr_ctrl_d   = commit_d && req_wr_q && (req_off_q == OFF_CTRL) && req_wstrb_q[0];
  assign wr_thresh_d = commit_d && req_wr_q && (req_off_q == OFF_THRESH) && req_wstrb_q[0];
  assign flush_d     = wr_ctrl_d && req_wdata_q[CTRL_FLUSH_BIT];
  assign clr_ovf_d   = commit_d && req_wr_q && (req_off_q == OFF_STATUS) &&
                       req_wstrb_q[1] && req_wdata_q[STATUS_OVF_BIT];
  assign thresh_wr_d = (req_wdata_q[CNT_W-1:0] > CNT_W'(DEPTH)) ?
                       CNT_W'(DEPTH) : req_wdata_q[CNT_W-1:0];

  // Pixel side: a pixel offered while enabled and full is dropped and flagged
  assign pixel_ready = en_q && !fifo_full;
  assign push_d      = pixel_valid && pixel_ready;
  assign ovf_set_d   = pixel_valid && en_q && fifo_full;

  // Control, threshold and overflow registers; a new overflow beats a same-edge clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      thresh_q <= '0;
`ifdef IOMEM_PIXRESP_PACK4_EN
      last_popn_q <= '0;
`endif
    end else begin
      if (wr_ctrl_d) begin
        en_q     <= req_wdata_q[CTRL_EN_BIT];
        irq_en_q <= req_wdata_q[CTRL_IRQ_EN_BIT];
      end
      if (wr_thresh_d) begin
        thresh_q <= thresh_wr_d;
      end
      if (ovf_set_d) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf_d) begin
        ovf_q <= 1'b0;
      end
`ifdef IOMEM_PIXRESP_PACK4_EN
      if (data_rd_d) begin
        last_popn_q <= req_popn_q;
      end
`endif
    end
  end

  pixel_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_d),
    .din_i   (pixel_in),
    .pop_i   (pop_d),
    .pop_n_i (req_popn_q),
    .flush_i (flush_d),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .look_o  (fifo_look)
  );

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign irq = irq_en_q && (thresh_q != '0) && (fifo_count >= thresh_q);

  // Address, data and strobe bits outside the decoded fields are intentionally ignored
  logic w_unused_bits;
`ifdef IOMEM_PIXRESP_PACK4_EN
  assign w_unused_bits = ^{iomem_addr[23:4], iomem_addr[1:0], iomem_wdata[31:16],
                           req_wdata_q};
`else
  assign w_unused_bits = ^{iomem_addr[23:4], iomem_addr[1:0], iomem_wdata[31:16],
                           req_wdata_q, fifo_look[31:8]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_iomem_pixel_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iomem_pixel_responder
//  Description : Scoreboard bench for iomem_pixel_responder. A queue-based
//                reference model predicts every bus response and the
//                irq / pixel_ready levels; a monitor compares on each ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iomem_pixel_responder;

  localparam int          DEPTH = 16;
  localparam int          CNT_W = 5;
  localparam logic [7:0]  BASE  = 8'h03;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = '0;
  logic [31:0] iomem_wdata = '0;
  logic [31:0] iomem_rdata;
  logic [7:0]  pixel_in = 8'h00;
  logic        pixel_valid = 1'b0;
  logic        pixel_ready;
  logic        irq;

  iomem_pixel_responder #(
    .BASE_ADDR_HI (BASE),
    .DEPTH        (DEPTH),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    bit          chk;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];
  exp_t e_mon;

  // Reference model state
  byte unsigned mq[$];
  bit  m_en, m_irqen, m_ovf;
  int  m_thresh, m_lastpop, pend_pop;

  // Stimulus coordination
  bit          ev_sel, ev_commit, rnd_pix;
  int          pix_pct = 50;
  logic [31:0] p_addr, p_wd;
  logic [3:0]  p_strb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int read_popn();
`ifdef IOMEM_PIXRESP_PACK4_EN
    return (mq.size() > 4) ? 4 : mq.size();
`else
    return (mq.size() > 0) ? 1 : 0;
`endif
  endfunction

  function automatic logic [31:0] exp_read(input logic [1:0] off);
    logic [31:0] v;
    v = '0;
    case (off)
      2'd0: begin
`ifdef IOMEM_PIXRESP_PACK4_EN
        for (int i = 0; i < read_popn(); i++) v[8*i +: 8] = mq[i];
`else
        v = (mq.size() == 0) ? 32'h100 : 32'(mq[0]);
`endif
      end
      2'd1: begin
        v = 32'(mq.size()) + (m_ovf ? 32'h100 : 32'h0);
`ifdef IOMEM_PIXRESP_PACK4_EN
        v = v + 32'(m_lastpop * 4096);
`endif
      end
      2'd2: v = {30'b0, m_irqen, m_en};
      default: v = 32'(m_thresh);
    endcase
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_en = 0; m_irqen = 0; m_ovf = 0;
    m_thresh = 0; m_lastpop = 0; pend_pop = 0;
  endtask

  // Apply everything that happens at one rising edge, using pre-edge state
  task automatic model_edge();
    bit full, push, ovf_set, flush, clr;
    exp_t e;
    full    = (mq.size() == DEPTH);
    push    = pixel_valid && m_en && !full;
    ovf_set = pixel_valid && m_en && full;
    flush   = 0;
    clr     = 0;
    if (ev_sel) begin
      e.cyc = cyc + 1;
      e.chk = (p_strb == 4'h0);
      e.val = e.chk ? exp_read(p_addr[3:2]) : 32'h0;
      pend_pop = (e.chk && p_addr[3:2] == 2'd0) ? read_popn() : 0;
      sb.push_back(e);
    end
    if (ev_commit) begin
      if (p_strb == 4'h0) begin
        if (p_addr[3:2] == 2'd0) begin
          repeat (pend_pop) void'(mq.pop_front());
          m_lastpop = pend_pop;
        end
      end else begin
        case (p_addr[3:2])
          2'd1: if (p_strb[1] && p_wd[8]) clr = 1;
          2'd2: if (p_strb[0]) begin
            m_en = p_wd[0]; m_irqen = p_wd[1]; flush = p_wd[2];
          end
          2'd3: if (p_strb[0]) m_thresh = (int'(p_wd[4:0]) > DEPTH) ? DEPTH : int'(p_wd[4:0]);
          default: ;
        endcase
      end
    end
    if (flush) mq.delete();
    else if (push) mq.push_back(pixel_in);
    if (clr) m_ovf = 0;
    if (ovf_set) m_ovf = 1;
  endtask

  task automatic tick();
    if (rnd_pix) begin
      pixel_valid = ($urandom_range(0, 99) < pix_pct);
      pixel_in    = 8'($urandom);
    end
    @(posedge clk);
    if (!reset) model_edge();
    cyc++;
    #1;
  endtask

  task automatic bus(input logic [31:0] addr, input logic [3:0] strb,
                     input logic [31:0] wd, input int hold);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = strb;
    iomem_wdata = wd;
    if (addr[31:24] != BASE) begin
      repeat (3 + hold) tick();
      iomem_valid = 1'b0;
      tick();
    end else begin
      p_addr = addr; p_strb = strb; p_wd = wd;
      ev_sel = 1; tick(); ev_sel = 0;
      ev_commit = 1; tick(); ev_commit = 0;
      repeat (hold) tick();
      iomem_valid = 1'b0;
      tick();
    end
  endtask

  function automatic logic [31:0] reg_addr(input logic [1:0] off);
    return {BASE, 20'($urandom), off, 2'($urandom)};
  endfunction

  task automatic rd(input logic [1:0] off);
    bus(reg_addr(off), 4'h0, $urandom, 0);
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] wd);
    bus(reg_addr(off), 4'hF, wd, 0);
  endtask

  task automatic push_px(input logic [7:0] b);
    pixel_valid = 1'b1;
    pixel_in    = b;
    tick();
    pixel_valid = 1'b0;
  endtask

  // Monitor: reset levels, continuous irq / pixel_ready levels, scoreboard on every ack
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_ready", 32'(iomem_ready), 32'h0);
      chk("rst_rdata", iomem_rdata, 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_pixel_ready", 32'(pixel_ready), 32'h0);
    end else begin
      chk("pixel_ready", 32'(pixel_ready), 32'(m_en && mq.size() < DEPTH));
      chk("irq", 32'(irq), 32'(m_irqen && m_thresh != 0 && mq.size() >= m_thresh));
      if (iomem_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_ack: got ready=1 expected ready=0 (cycle %0d)", cyc);
        end else begin
          e_mon = sb.pop_front();
          chk("ack_cycle", 32'(cyc), 32'(e_mon.cyc));
          if (e_mon.chk) chk("rdata", iomem_rdata, e_mon.val);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int op;
    model_reset();
    rnd_pix = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state visible through STATUS
    rd(2'd1);

    // Three pixels in, drained in order, then empty
    wr(2'd2, 32'h1);
    push_px(8'h11); push_px(8'h22); push_px(8'h33);
    rd(2'd1);
    repeat (4) rd(2'd0);

    // Fill, overflow by one, clear OVF
    for (int i = 0; i < DEPTH + 1; i++) push_px(8'($urandom));
    rd(2'd1);
    wr(2'd1, 32'h100);
    rd(2'd1);
    wr(2'd2, 32'h5);

    // Threshold IRQ
    wr(2'd3, 32'h4);
    wr(2'd2, 32'h3);
    for (int i = 0; i < 4; i++) push_px(8'(8'h40 + i));
    rd(2'd0);
    rd(2'd3);
    wr(2'd3, 32'h1F);
    rd(2'd3);

    // Long-held request acks and pops once; foreign address is ignored
    bus(reg_addr(2'd0), 4'h0, 32'h0, 3);
    rd(2'd1);
    bus({8'h02, 20'h0, 2'd1, 2'b00}, 4'h0, 32'h0, 2);

    // Flush while pixels keep arriving
    rnd_pix = 1; pix_pct = 100;
    wr(2'd2, 32'h5);
    rd(2'd2);
    rd(2'd1);
    rnd_pix = 0; pixel_valid = 1'b0;

    // Six bytes in, one DATA read
    for (int i = 0; i < 6; i++) push_px(8'(8'hA0 + i));
    rd(2'd0);
    rd(2'd1);

    // Reset in the middle of an acknowledge
    iomem_valid = 1'b1;
    iomem_addr  = reg_addr(2'd1);
    iomem_wstrb = 4'h0;
    tick();
    reset = 1'b1;
    model_reset();
    iomem_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    rd(2'd1);

    // Randomised traffic with concurrent pixel stream
    wr(2'd2, 32'h1);
    rnd_pix = 1;
    for (int n = 0; n < 400; n++) begin
      pix_pct = $urandom_range(0, 100);
      op = $urandom_range(0, 11);
      case (op)
        0, 1, 2, 3, 4: bus(reg_addr(2'd0), 4'h0, $urandom, $urandom_range(0, 2));
        5: bus(reg_addr(2'd1), 4'h0, $urandom, $urandom_range(0, 2));
        6: bus(reg_addr(2'($urandom_range(2, 3))), 4'h0, $urandom, 0);
        7: bus(reg_addr(2'd2), 4'($urandom_range(1, 15)),
               {29'($urandom), ($urandom_range(0, 9) == 0), 1'($urandom),
                ($urandom_range(0, 4) != 0)}, $urandom_range(0, 1));
        8: bus(reg_addr(2'd3), 4'($urandom_range(1, 15)), $urandom, 0);
        9: bus(reg_addr(2'd1), 4'($urandom_range(1, 15)), $urandom, 0);
        10: bus({8'($urandom_range(4, 255)), 24'($urandom)}, 4'($urandom), $urandom, 0);
        default: repeat ($urandom_range(1, 5)) tick();
      endcase
    end
    rnd_pix = 0;
    pixel_valid = 1'b0;
    repeat (3) tick();
    chk("pending_acks", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
